// File: rtl/wbm_spi_tx_fifo.sv
// wbm_spi_tx_fifo
//   SPI slave transmitter that runs entirely in the system clock domain.
//   spi_sck and spi_csn are oversampled through 2-FF synchronisers, so
//   f_clk must be at least 8*f_sck. A DEPTH-word FIFO is written through a
//   valid/ready interface, and each word is shifted out on spi_sdo. When the
//   FIFO is empty at a word boundary, IDLE_WORD is sent and underrun_o pulses.
//
// Ports
//   wb_clk_i    system clock
//   wb_rst_ni   async reset, active-low
//   spi_sck     SPI clock from master (async)
//   spi_csn     chip select, active-low (async)
//   spi_sdo     serial data out (MISO)
//   tx_data_i   word to enqueue
//   tx_valid_i  tx_data_i valid
//   tx_ready_o  FIFO not full
//   tx_level_o  FIFO word count
//   underrun_o  1-cycle pulse when IDLE_WORD is loaded
//   busy_o      frame in progress
//
// State table
//   state    | meaning
//   S_IDLE   | chip select high, spi_sdo held low, waiting for csn fall
//   S_ACTIVE | frame in progress, shifting on shift_ev
module wbm_spi_tx_fifo #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       spi_sck,
  input  logic                       spi_csn,
  output logic                       spi_sdo,
  input  logic [DATA_W-1:0]          tx_data_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  output logic [$clog2(DEPTH):0]     tx_level_o,
  output logic                       underrun_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t state, state_next;

  logic sck_meta, sck_s, sck_d;
  logic csn_meta, csn_s;
  logic lead, trail, shift_ev;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              push, pop, empty;

  logic [CW-1:0]     bit_cnt, cnt_next;
  logic [DATA_W-1:0] sreg, sreg_sh, load_word;
  logic              do_load, do_shift, do_clear;

  // Synchronisers reset to the idle pin levels so no edge is seen at reset exit.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sck_meta <= CPOL;
      sck_s    <= CPOL;
      sck_d    <= CPOL;
      csn_meta <= 1'b1;
      csn_s    <= 1'b1;
    end else begin
      sck_meta <= spi_sck;
      sck_s    <= sck_meta;
      sck_d    <= sck_s;
      csn_meta <= spi_csn;
      csn_s    <= csn_meta;
    end
  end

  assign lead     = (sck_s != sck_d) && (sck_s != CPOL);
  assign trail    = (sck_s != sck_d) && (sck_s == CPOL);
  assign shift_ev = CPHA ? lead : trail;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_next;
  end

  // A csn rise takes priority over a coincident shift event.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!csn_s) begin
          state_next = S_ACTIVE;
          cnt_next   = '0;
          do_load    = !CPHA;
        end
      end
      S_ACTIVE: begin
        if (csn_s) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          do_clear   = 1'b1;
        end else if (shift_ev) begin
          if (!CPHA) begin
            if (bit_cnt == CNT_MAX) begin
              cnt_next = '0;
              do_load  = 1'b1;
            end else begin
              cnt_next = bit_cnt + CNT_ONE;
              do_shift = 1'b1;
            end
          end else begin
            do_load  = (bit_cnt == '0);
            do_shift = (bit_cnt != '0);
            cnt_next = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + CNT_ONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign empty      = (level == '0);
  assign tx_ready_o = (level != LVL_FULL);
  assign push       = tx_valid_i && tx_ready_o;
  assign pop        = do_load && !empty;
  assign load_word  = empty ? IDLE_WORD : mem[rd_ptr];
  assign sreg_sh    = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      spi_sdo    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      bit_cnt    <= cnt_next;
      underrun_o <= do_load && empty;

      if (do_clear) begin
        spi_sdo <= 1'b0;
      end else if (do_load) begin
        sreg    <= load_word;
        spi_sdo <= LSB_FIRST ? load_word[0] : load_word[DATA_W-1];
      end else if (do_shift) begin
        sreg    <= sreg_sh;
        spi_sdo <= LSB_FIRST ? sreg_sh[0] : sreg_sh[DATA_W-1];
      end
    end
  end

  assign tx_level_o = level;
  assign busy_o     = (state == S_ACTIVE);

endmodule
